// File: rtl/button_conditioner_pkg.sv
// Shared constants and helpers for the button/switch input conditioner.
package button_conditioner_pkg;

  // Defaults for a 125 MHz fabric clock: 500 us sample period, 100 ms hold.
  localparam int DEF_WIDTH          = 4;
  localparam int DEF_SAMPLE_CNT_MAX = 62500;
  localparam int DEF_PULSE_CNT_MAX  = 200;

  // Short-time values so simulations reach a debounced level in a few cycles.
  localparam int SIM_SAMPLE_CNT_MAX = 4;
  localparam int SIM_PULSE_CNT_MAX  = 3;

  // Counter width for a value range of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_conditioner_sync.sv
// Two-stage synchronizer for a bus of independent asynchronous inputs.
module button_conditioner_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; the second stage gives it a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Button/switch conditioner: synchronize, debounce by sampled saturating count,
// and emit a one-cycle pulse on each debounced rising edge, per bit.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] pulse_out
);

  localparam int CW = cnt_width(SAMPLE_CNT_MAX);
  localparam int SW = cnt_width(PULSE_CNT_MAX + 1);
  localparam logic [CW-1:0] SMP_LAST = CW'(SAMPLE_CNT_MAX - 1);
  localparam logic [SW-1:0] SAT_MAX  = SW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    smp_cnt_q;
  logic [CW-1:0]    smp_cnt_d;
  logic             tick;
  logic [WIDTH-1:0] level_q;

  button_conditioner_sync #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (in),
    .q_o (sync)
  );

  // Shared sample-tick generator: tick on the last count, then wrap to zero.
  always_comb begin
    tick      = (smp_cnt_q == SMP_LAST);
    smp_cnt_d = tick ? '0 : smp_cnt_q + CW'(1);
  end

  // Free-running sample counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) smp_cnt_q <= '0;
    else     smp_cnt_q <= smp_cnt_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [SW-1:0] sat_q;
    logic [SW-1:0] sat_d;

    // Any low sync cycle restarts the count; high samples climb to MAX and stick.
    always_comb begin
      sat_d = sat_q;
      if (!sync[i])                    sat_d = '0;
      else if (tick && sat_q != SAT_MAX) sat_d = sat_q + SW'(1);
    end

    // Per-bit debounce counter register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sat_q <= '0;
      else     sat_q <= sat_d;
    end

    assign level_out[i] = (sat_q == SAT_MAX);
  end

  // Level history for edge detection; cleared so reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= '0;
    else     level_q <= level_out;
  end

  assign pulse_out = level_out & ~level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short sample/hold constants.
module tb_button_conditioner;

  localparam int W = 4;
  localparam int S = 4;
  localparam int P = 3;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_s;
  logic [W-1:0] level_out;
  logic [W-1:0] pulse_out;

  int vectors;
  int miscompares;
  int cyc;

  // Scoreboard: expected pulse masks pushed at stimulus, observed ones from the monitor.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_mask_q[$];
  int           obs_cyc_q[$];
  int           rise_cyc[W];
  logic [W-1:0] lvl_prev;

  button_conditioner #(
    .WIDTH          (W),
    .SAMPLE_CNT_MAX (S),
    .PULSE_CNT_MAX  (P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_s),
    .level_out (level_out),
    .pulse_out (pulse_out)
  );

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record pulses and level rise cycles at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (pulse_out != '0) begin
        obs_mask_q.push_back(pulse_out);
        obs_cyc_q.push_back(cyc);
      end
      for (int i = 0; i < W; i++)
        if (level_out[i] && !lvl_prev[i]) rise_cyc[i] = cyc;
      lvl_prev = level_out;
    end else begin
      lvl_prev = '0;
    end
  end

  task automatic set_in(input logic [W-1:0] v);
    @(posedge clk);
    #1;
    in_s = v;
  endtask

  task automatic clear_obs();
    obs_mask_q.delete();
    obs_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    in_s = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (level_out !== '0) begin
      miscompares++;
      $display("FAIL reset_level: got %b want 0000", level_out);
    end
    vectors++;
    if (pulse_out !== '0) begin
      miscompares++;
      $display("FAIL reset_pulse: got %b want 0000", pulse_out);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (level_out !== '0 || pulse_out !== '0) begin
      miscompares++;
      $display("FAIL reset_release: level %b pulse %b want 0000/0000", level_out, pulse_out);
    end
  endtask

  task automatic test_clean_press();
    int t0;
    clear_obs();
    set_in(4'b0001);
    t0 = cyc;
    exp_q.push_back(4'b0001);
    repeat (30) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (obs_mask_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL press_pulse_count: got %0d want %0d", obs_mask_q.size(), exp_q.size());
    end else begin
      logic [W-1:0] e;
      int           c;
      e = exp_q.pop_front();
      c = obs_cyc_q[0];
      vectors++;
      if (obs_mask_q[0] !== e) begin
        miscompares++;
        $display("FAIL press_pulse_mask: got %b want %b", obs_mask_q[0], e);
      end
      vectors++;
      if (c < t0 + 11 || c > t0 + 15) begin
        miscompares++;
        $display("FAIL press_latency: got %0d want %0d..%0d", c - t0, 11, 15);
      end
      vectors++;
      if (rise_cyc[0] != c) begin
        miscompares++;
        $display("FAIL press_align: level rise %0d pulse %0d", rise_cyc[0], c);
      end
    end
    vectors++;
    if (level_out !== 4'b0001) begin
      miscompares++;
      $display("FAIL press_level: got %b want 0001", level_out);
    end
  endtask

  task automatic test_bounce();
    logic b;
    clear_obs();
    b = 1'b0;
    for (int k = 0; k < 40; k += 3) begin
      b = ~b;
      set_in({2'b00, b, 1'b1});
      repeat (2) @(posedge clk);
    end
    set_in(4'b0001);
    repeat (20) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (obs_mask_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL bounce_pulses: got %0d want %0d", obs_mask_q.size(), exp_q.size());
    end
    vectors++;
    if (level_out[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_level: got %b want 0", level_out[1]);
    end
  endtask

  task automatic test_release();
    clear_obs();
    set_in(4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (level_out[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL release_early: got %b want 1 at cycle 2", level_out[0]);
    end
    @(negedge clk);
    vectors++;
    if (level_out[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL release_fall: got %b want 0 at cycle 3", level_out[0]);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (obs_mask_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL release_pulse: got %0d want %0d", obs_mask_q.size(), exp_q.size());
    end
  endtask

  task automatic test_hold_long();
    int   drops;
    logic seen;
    clear_obs();
    drops = 0;
    seen  = 1'b0;
    set_in(4'b0100);
    exp_q.push_back(4'b0100);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (seen && !level_out[2]) drops++;
      if (level_out[2]) seen = 1'b1;
    end
    vectors++;
    if (obs_mask_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL hold_pulse_count: got %0d want %0d", obs_mask_q.size(), exp_q.size());
    end else begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      vectors++;
      if (obs_mask_q[0] !== e) begin
        miscompares++;
        $display("FAIL hold_pulse_mask: got %b want %b", obs_mask_q[0], e);
      end
    end
    vectors++;
    if (drops != 0 || level_out[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_level: drops %0d level %b want 0 drops level 1", drops, level_out[2]);
    end
    set_in(4'b0000);
    repeat (6) @(posedge clk);
  endtask

  task automatic test_simultaneous();
    clear_obs();
    set_in(4'hF);
    exp_q.push_back(4'hF);
    repeat (30) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (obs_mask_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL simul_pulse_count: got %0d want %0d", obs_mask_q.size(), exp_q.size());
    end else begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      vectors++;
      if (obs_mask_q[0] !== e) begin
        miscompares++;
        $display("FAIL simul_pulse_mask: got %b want %b", obs_mask_q[0], e);
      end
    end
    vectors++;
    if (level_out !== 4'hF) begin
      miscompares++;
      $display("FAIL simul_level: got %b want 1111", level_out);
    end
  endtask

  task automatic test_reset_mid_press();
    int t0;
    set_in(4'b0001);
    repeat (6) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (level_out !== 4'b0001) begin
      miscompares++;
      $display("FAIL midrst_pre_level: got %b want 0001", level_out);
    end
    clear_obs();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (level_out !== '0 || pulse_out !== '0) begin
      miscompares++;
      $display("FAIL midrst_async: level %b pulse %b want 0000/0000", level_out, pulse_out);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    t0 = cyc;
    exp_q.push_back(4'b0001);
    @(negedge clk);
    vectors++;
    if (pulse_out !== '0) begin
      miscompares++;
      $display("FAIL midrst_release_pulse: got %b want 0000", pulse_out);
    end
    repeat (30) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (obs_mask_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL midrst_pulse_count: got %0d want %0d", obs_mask_q.size(), exp_q.size());
    end else begin
      logic [W-1:0] e;
      int           c;
      e = exp_q.pop_front();
      c = obs_cyc_q[0];
      vectors++;
      if (obs_mask_q[0] !== e) begin
        miscompares++;
        $display("FAIL midrst_pulse_mask: got %b want %b", obs_mask_q[0], e);
      end
      vectors++;
      if (c < t0 + 11 || c > t0 + 15) begin
        miscompares++;
        $display("FAIL midrst_latency: got %0d want %0d..%0d", c - t0, 11, 15);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    lvl_prev    = '0;
    for (int i = 0; i < W; i++) rise_cyc[i] = -1;
    rst  = 1'b1;
    in_s = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_hold_long();
    test_simultaneous();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
